// File: rtl/ram_dma_ci.sv
// Custom-instruction scratch RAM for the DMA controller: 512 x 32-bit, one port.
// Writes complete in the issuing cycle; reads return registered data one cycle later.
module ram_dma_ci #(
  parameter logic [7:0] customId = 8'h00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  input  logic [7:0]  ciN,
  output logic [31:0] result,
  output logic        done
);

  localparam int          DEPTH    = 512;
  localparam logic [2:0]  FUNC_MEM = 3'b000;

  logic [31:0] mem [0:DEPTH-1];

  logic        select;
  logic        wr_en;
  logic        rd_en;
  logic [8:0]  addr;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        unused_cmd_bits;

  // Only function code 000 touches the array; the wrapper answers the other codes.
  assign select = start && (ciN == customId) && (valueA[12:10] == FUNC_MEM);
  assign addr   = valueA[8:0];
  assign wr_en  = select && valueA[9] && !reset;
  assign rd_en  = select && !valueA[9] && !reset;

  assign unused_cmd_bits = ^valueA[31:13];

  // NOTE: the array has no reset branch so it maps onto a block RAM; clearing it
  // would force 16k flops and a reset mux on every bit.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      // NOTE: non-blocking so every flop samples pre-edge values, exactly as hardware does.
      mem[addr] <= valueB;
    end
  end

  // Read data needs no reset: it is only visible while rd_valid is set.
  always_ff @(posedge clock) begin
    if (rd_en) begin
      rd_data <= mem[addr];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
    end
  end

  // A write's same-cycle done may overlap the previous read's done; the read data wins.
  assign done   = wr_en || rd_valid;
  assign result = rd_valid ? rd_data : 32'h0;

endmodule

// File: tb/tb_ram_dma_ci.sv
// Directed vector bench for ram_dma_ci: one table row per clock cycle, plus
// hand-written reset sequences around in-flight reads and writes.
module tb_ram_dma_ci;

  localparam logic [7:0] CID = 8'h00;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic [7:0]  ciN;
  logic [31:0] result;
  logic        done;

  int vectors;
  int miscompares;

  typedef struct {
    string       name;
    logic        start;
    logic [7:0]  ci;
    logic [31:0] a;
    logic [31:0] b;
    logic        exp_done;
    logic [31:0] exp_result;
  } vec_t;

  ram_dma_ci #(.customId(CID)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .valueA (valueA),
    .valueB (valueB),
    .ciN    (ciN),
    .result (result),
    .done   (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic exp_done, input logic [31:0] exp_result);
    vectors++;
    if (done !== exp_done || result !== exp_result) begin
      miscompares++;
      $display("FAIL %s: got done=%b result=%h, expected done=%b result=%h",
               name, done, result, exp_done, exp_result);
    end
  endtask

  // Drive one cycle's inputs just after the edge, check mid-cycle, then advance.
  task automatic cycle(input string name, input logic rst, input logic st, input logic [7:0] ci,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic chk, input logic exp_done, input logic [31:0] exp_result);
    reset  = rst;
    start  = st;
    ciN    = ci;
    valueA = a;
    valueB = b;
    #4;
    if (chk) check(name, exp_done, exp_result);
    @(posedge clock);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset  = 1'b1;
    start  = 1'b0;
    ciN    = CID;
    valueA = 32'h0;
    valueB = 32'h0;

    //          name              start ci     valueA        valueB        done result
    vecs.push_back('{"wr5",        1'b1, CID,   32'h0000_0205, 32'hDEAD_BEEF, 1'b1, 32'h0});
    vecs.push_back('{"rd5_issue",  1'b1, CID,   32'h0000_0005, 32'h0,         1'b0, 32'h0});
    vecs.push_back('{"rd5_data",   1'b0, CID,   32'h0,         32'h0,         1'b1, 32'hDEAD_BEEF});
    vecs.push_back('{"rd5_idle",   1'b0, CID,   32'h0,         32'h0,         1'b0, 32'h0});
    vecs.push_back('{"wr0",        1'b1, CID,   32'h0000_0200, 32'h10,        1'b1, 32'h0});
    vecs.push_back('{"wr1",        1'b1, CID,   32'h0000_0201, 32'h11,        1'b1, 32'h0});
    vecs.push_back('{"wr2",        1'b1, CID,   32'h0000_0202, 32'h12,        1'b1, 32'h0});
    vecs.push_back('{"wr3",        1'b1, CID,   32'h0000_0203, 32'h13,        1'b1, 32'h0});
    vecs.push_back('{"b2b_rd0",    1'b1, CID,   32'h0000_0000, 32'h0,         1'b0, 32'h0});
    vecs.push_back('{"b2b_rd1",    1'b1, CID,   32'h0000_0001, 32'h0,         1'b1, 32'h10});
    vecs.push_back('{"b2b_rd2",    1'b1, CID,   32'h0000_0002, 32'h0,         1'b1, 32'h11});
    vecs.push_back('{"b2b_rd3",    1'b1, CID,   32'h0000_0003, 32'h0,         1'b1, 32'h12});
    vecs.push_back('{"b2b_last",   1'b0, CID,   32'h0,         32'h0,         1'b1, 32'h13});
    vecs.push_back('{"b2b_idle",   1'b0, CID,   32'h0,         32'h0,         1'b0, 32'h0});
    vecs.push_back('{"wr_bad_ci",  1'b1, CID+1, 32'h0000_0205, 32'h1,         1'b0, 32'h0});
    vecs.push_back('{"wr_func011", 1'b1, CID,   32'h0000_0E05, 32'h2,         1'b0, 32'h0});
    vecs.push_back('{"rd_bad_ci",  1'b1, CID+1, 32'h0000_0005, 32'h0,         1'b0, 32'h0});
    vecs.push_back('{"bad_ci_gap", 1'b0, CID,   32'h0,         32'h0,         1'b0, 32'h0});
    vecs.push_back('{"rd5_again",  1'b1, CID,   32'h0000_0005, 32'h0,         1'b0, 32'h0});
    vecs.push_back('{"rd5_kept",   1'b0, CID,   32'h0,         32'h0,         1'b1, 32'hDEAD_BEEF});
    vecs.push_back('{"wr511",      1'b1, CID,   32'h0000_03FF, 32'hA5A5_A5A5, 1'b1, 32'h0});
    vecs.push_back('{"rd511",      1'b1, CID,   32'h0000_01FF, 32'h0,         1'b0, 32'h0});
    vecs.push_back('{"rd0_issue",  1'b1, CID,   32'h0000_0000, 32'h0,         1'b1, 32'hA5A5_A5A5});
    vecs.push_back('{"rd0_intact", 1'b0, CID,   32'h0,         32'h0,         1'b1, 32'h10});
    vecs.push_back('{"wr7",        1'b1, CID,   32'h0000_0207, 32'hCAFE_F00D, 1'b1, 32'h0});
    vecs.push_back('{"rd7_after",  1'b1, CID,   32'h0000_0007, 32'h0,         1'b0, 32'h0});
    vecs.push_back('{"rd_wr_ovl",  1'b1, CID,   32'h0000_0208, 32'h55,        1'b1, 32'hCAFE_F00D});
    vecs.push_back('{"ovl_idle",   1'b0, CID,   32'h0,         32'h0,         1'b0, 32'h0});
    vecs.push_back('{"no_start",   1'b0, CID,   32'h0000_0205, 32'h0,         1'b0, 32'h0});
    vecs.push_back('{"rd5_chk",    1'b1, CID,   32'h0000_0005, 32'h0,         1'b0, 32'h0});
    vecs.push_back('{"rd8_issue",  1'b1, CID,   32'h0000_0008, 32'h0,         1'b1, 32'hDEAD_BEEF});
    vecs.push_back('{"rd8_data",   1'b0, CID,   32'h0,         32'h0,         1'b1, 32'h55});
    vecs.push_back('{"rd8_idle",   1'b0, CID,   32'h0,         32'h0,         1'b0, 32'h0});

    // Reset held for two cycles, then released with start low.
    @(posedge clock);
    #1;
    cycle("reset_c1",  1'b1, 1'b0, CID, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    cycle("reset_c2",  1'b1, 1'b0, CID, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    cycle("reset_rel", 1'b0, 1'b0, CID, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);

    foreach (vecs[i]) begin
      cycle(vecs[i].name, 1'b0, vecs[i].start, vecs[i].ci, vecs[i].a, vecs[i].b,
            1'b1, vecs[i].exp_done, vecs[i].exp_result);
    end

    // Read in flight when reset arrives: discarded, memory retained.
    cycle("rst_rd_issue", 1'b0, 1'b1, CID, 32'h0000_0005, 32'h0, 1'b1, 1'b0, 32'h0);
    cycle("rst_assert",   1'b1, 1'b0, CID, 32'h0,         32'h0, 1'b0, 1'b0, 32'h0);
    cycle("rst_after",    1'b0, 1'b0, CID, 32'h0,         32'h0, 1'b1, 1'b0, 32'h0);

    // Read issued during reset produces nothing afterwards.
    cycle("rst_rd_in",    1'b1, 1'b1, CID, 32'h0000_0005, 32'h0, 1'b0, 1'b0, 32'h0);
    cycle("rst_rd_drop",  1'b0, 1'b0, CID, 32'h0,         32'h0, 1'b1, 1'b0, 32'h0);

    // Write issued during reset is not performed.
    cycle("rst_wr_in",    1'b1, 1'b1, CID, 32'h0000_0205, 32'h0000_0BAD, 1'b0, 1'b0, 32'h0);
    cycle("post_rd5",     1'b0, 1'b1, CID, 32'h0000_0005, 32'h0, 1'b1, 1'b0, 32'h0);
    cycle("post_rd511",   1'b0, 1'b1, CID, 32'h0000_01FF, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    cycle("post_rd0",     1'b0, 1'b1, CID, 32'h0000_0000, 32'h0, 1'b1, 1'b1, 32'hA5A5_A5A5);
    cycle("post_last",    1'b0, 1'b0, CID, 32'h0,         32'h0, 1'b1, 1'b1, 32'h10);
    cycle("post_idle",    1'b0, 1'b0, CID, 32'h0,         32'h0, 1'b1, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
